bit_serializer: RTL
===================

Name: bit_serializer

Overview:
Parallel-to-serial front end. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock as a serial stream with a qualifying valid. It sits directly upstream of the 1101 sequence detector and drives that detector's data_in. An optional idle gap between words lets benches and the datapath insert inter-word spacing.

Parameters:
WIDTH, 8, word width in bits; must be >= 2.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
GAP_CYCLES, 0, number of idle cycles (serial_valid=0) inserted after each word; range 0..255.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush of the pending and in-flight word
in_data  input  WIDTH  parallel word
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
serial_out  output  1  serial bit; feeds the detector's data_in
serial_valid  output  1  serial_out carries a live bit this cycle
word_done  output  1  one-cycle pulse, concurrent with the last bit of a word
busy  output  1  a pending word or in-flight word exists, or a gap is running

Behaviour:
- Reset is asynchronous and active-high; the single clock is clk.
- Reset values: serial_out=0, serial_valid=0, word_done=0, busy=0, in_ready=1. FSM=IDLE; pending buffer empty; bit counter=0; gap counter=0.
- Storage: a 1-entry pending register (pend_data, pend_valid) plus a WIDTH-bit shift register.
- in_ready = ~pend_valid. It is driven from a flop, with no combinational path from in_valid.
- Accept: in_valid & in_ready at a rising edge loads pend_data and sets pend_valid. in_data is ignored when not accepted.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If pend_valid: load the shift register from pend_data, clear pend_valid, go to SHIFT, bit counter=0.
  - Latency is 2 edges: a word accepted at edge k presents its first bit on serial_out after edge k+1.
- SHIFT:
  - serial_out is the current head bit (MSB or LSB per MSB_FIRST); serial_valid=1.
  - The register shifts each cycle and the counter increments.
  - When counter==WIDTH-1, word_done=1 that cycle.
  - On the next edge after the last bit:
    - GAP_CYCLES>0: go to GAP with gap counter=GAP_CYCLES-1.
    - else if pend_valid: reload from pending and stay in SHIFT. There is no bubble; back-to-back words form a continuous stream.
    - else: go to IDLE.
  - A word accepted in the same cycle as the last bit is not yet visible as pend_valid. It loads one cycle later, giving one bubble. This is required behaviour and must not be optimised away.
- GAP:
  - serial_valid=0 and serial_out=0.
  - When the gap counter reaches 0: go to SHIFT if pend_valid (reload), else go to IDLE.
- Outside SHIFT: serial_out=0, serial_valid=0, word_done=0.
- The serial outputs are registered. serial_out, serial_valid and word_done change only on clk edges.
- busy = pend_valid | (state != IDLE).
- clear (synchronous, highest priority below reset):
  - Next edge: FSM=IDLE, pend_valid=0, counters=0, serial_valid=0.
  - A word offered with in_valid in the same cycle as clear is dropped, even if in_ready=1.
  - A word_done pending for that cycle is suppressed.
- Reset mid-word: outputs return immediately (asynchronously) to reset values. The partial word is discarded and no word_done is issued.
- in_valid held high with in_ready=0: no data is lost or overwritten; pend_data is stable until consumed.

Decomposition:
- Shared package (serializer_pkg): state encoding IDLE=2'b00, SHIFT=2'b01, GAP=2'b10; default WIDTH/GAP_CYCLES constants; localparam width of the bit counter as $clog2(WIDTH).
- The detector's existing encodings stay separate; the package holds only serializer items.
- No sub-module is needed. The gap counter stays inline because it is under 10 lines.

Test Plan:
- Reset, then WIDTH=8, MSB_FIRST=1, GAP=0, one word 8'hD5 accepted at edge k -> serial_valid high from edge k+1 for 8 cycles. Bits 1,1,0,1,0,1,0,1 in that order. word_done on the 8th bit. A connected detector pulses detected exactly once.
- Two words 8'hFF then 8'h00 with in_valid held high -> 16 contiguous valid bits, no bubble. in_ready low while pending is full; word_done twice, 8 cycles apart.
- MSB_FIRST=0, word 8'h0B -> serial bits 1,1,0,1,0,0,0,0. GAP_CYCLES=3, next word 8'hA5 queued -> exactly 3 cycles with serial_valid=0 between the two words.
- Second word offered on the last-bit cycle of the first, pending empty -> exactly one bubble cycle, then the second word; no data loss.
- clear asserted on bit 4 of 8'hD5, with word 8'h3C pending -> next cycle serial_valid=0, busy=0, in_ready=1, no word_done. 8'h3C is never transmitted.
- Asynchronous reset pulse between clock edges mid-word -> outputs return to reset values immediately. A new word 8'h81 after reset serializes cleanly as 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/serializer_pkg.sv
// serializer_pkg: shared constants and FSM encoding for bit_serializer.
//   Holds serializer items only; the downstream 1101 detector keeps its own encodings.
package serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 8;
  localparam int unsigned DEFAULT_GAP_CYCLES = 0;
  // Gap counter holds GAP_CYCLES-1, so 8 bits cover the 0..255 range.
  localparam int unsigned GAP_CNT_W          = 8;
  localparam int unsigned DEFAULT_CNT_W      = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } ser_state_e;

  // Bit counter width for a given word width; WIDTH is at least 2.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end feeding the 1101 detector.
//   Accepts WIDTH-bit words over valid/ready into a 1-entry pending register,
//   then shifts them out one bit per clock, with an optional idle gap per word.
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous, active-high reset
//   clear        - synchronous flush of pending and in-flight word
//   in_data      - parallel word (WIDTH bits)
//   in_valid     - in_data is valid
//   in_ready     - registered, high when the pending register is empty
//   serial_out   - serial bit, drives the detector's data_in
//   serial_valid - serial_out carries a live bit
//   word_done    - pulse concurrent with the last bit of a word
//   busy         - pending word present or FSM not idle
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned          CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  ser_state_e             state_q, state_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0]   gap_q, gap_d;
  logic [WIDTH-1:0]       pend_data_q, pend_data_d;
  logic                   pend_valid_q, pend_valid_d;
  logic                   load;
  logic                   accept;
  logic                   sout_d, svalid_d, done_d, busy_d, ready_d;

  // Bit presented first from a word, per transmission order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Advance the shift register by one bit towards the head.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Next-state, datapath and registered-output inputs.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    load         = 1'b0;
    accept       = in_valid & ~pend_valid_q;

    case (state_q)
      IDLE: begin
        if (pend_valid_q) load = 1'b1;
      end
      SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
            cnt_d   = '0;
          end else if (pend_valid_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          shreg_d = shift_once(shreg_q);
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (pend_valid_q) load = 1'b1;
          else              state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Pending word moves into the shifter; pending and accept never coincide.
    if (load) begin
      state_d      = SHIFT;
      shreg_d      = pend_data_q;
      cnt_d        = '0;
      pend_valid_d = 1'b0;
    end

    if (accept) begin
      pend_data_d  = in_data;
      pend_valid_d = 1'b1;
    end

    // Flush drops the pending word, any word offered now, and the in-flight word.
    if (clear) begin
      state_d      = IDLE;
      cnt_d        = '0;
      gap_d        = '0;
      pend_valid_d = 1'b0;
    end

    // Outputs are registered from next-state so they align with the shifter.
    svalid_d = (state_d == SHIFT);
    sout_d   = (state_d == SHIFT) & head_bit(shreg_d);
    done_d   = (state_d == SHIFT) & (cnt_d == LAST_BIT);
    busy_d   = pend_valid_d | (state_d != IDLE);
    ready_d  = ~pend_valid_d;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      word_done    <= 1'b0;
      busy         <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      serial_out   <= sout_d;
      serial_valid <= svalid_d;
      word_done    <= done_d;
      busy         <= busy_d;
      in_ready     <= ready_d;
    end
  end

endmodule
